// File: rtl/scytale_decryption_pkg.sv
// Shared decryption constants: end-of-message token and the collect/decrypt state encoding.
// Every decryptor in the family imports these.
package scytale_decryption_pkg;

    localparam logic [7:0] DEC_START_TOKEN = 8'hFA;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_DECRYPT = 1'b1
    } dec_state_e;

endpackage

// File: rtl/scytale_decryption.sv
// Scytale decryptor: buffers ciphertext until the token arrives.
// It then replays the buffer column-major over an N x M grid, one character per cycle.
module scytale_decryption
    import scytale_decryption_pkg::*;
#(
    parameter int D_WIDTH       = 8,
    parameter int KEY_WIDTH     = 8,
    parameter int MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEC_START_TOKEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    output logic                 busy
);

    localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
    localparam int ADDR_W = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;
    localparam int IDX_W  = 2 * KEY_WIDTH;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_NOF_CHARS);
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(MAX_NOF_CHARS);

    logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];
    logic [CNT_W-1:0]     r_cnt;
    logic [KEY_WIDTH-1:0] r_i;
    logic [KEY_WIDTH-1:0] r_j;
    logic [KEY_WIDTH-1:0] r_key_n;
    logic [KEY_WIDTH-1:0] r_key_m;
    dec_state_e           r_state;

    logic                 w_token;
    logic                 w_store;
    logic                 w_row_last;
    logic                 w_col_last;
    logic [IDX_W-1:0]     w_idx;
    logic [D_WIDTH-1:0]   w_rd_data;

    assign w_token    = (data_i == START_DECRYPTION_TOKEN);
    assign w_store    = (r_state == ST_COLLECT) && valid_i && !w_token && (r_cnt < CNT_FULL);
    assign w_row_last = (r_i == (r_key_m - KEY_WIDTH'(1)));
    assign w_col_last = (r_j == (r_key_n - KEY_WIDTH'(1)));

    // Full-width row-major index i*N + j; cannot overflow 2*KEY_WIDTH bits.
    assign w_idx = ({{KEY_WIDTH{1'b0}}, r_i} * {{KEY_WIDTH{1'b0}}, r_key_n})
                 + {{KEY_WIDTH{1'b0}}, r_j};

    // Buffer read; an out-of-range index reads as zero instead of aliasing.
    always_comb begin
        w_rd_data = {D_WIDTH{1'b0}};
        if (w_idx < IDX_LIMIT) begin
            w_rd_data = r_buf[w_idx[ADDR_W-1:0]];
        end else begin
            w_rd_data = {D_WIDTH{1'b0}};
        end
    end

    // Character buffer; contents survive reset and are overwritten by the next message.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_cnt[ADDR_W-1:0]] <= data_i;
        end
    end

    // Collect/decrypt control with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_COLLECT;
            r_cnt   <= {CNT_W{1'b0}};
            r_i     <= {KEY_WIDTH{1'b0}};
            r_j     <= {KEY_WIDTH{1'b0}};
            r_key_n <= {KEY_WIDTH{1'b0}};
            r_key_m <= {KEY_WIDTH{1'b0}};
            data_o  <= {D_WIDTH{1'b0}};
            valid_o <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    data_o  <= {D_WIDTH{1'b0}};
                    valid_o <= 1'b0;
                    if (w_store) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    // An empty message never starts a decryption.
                    if (valid_i && w_token && (r_cnt != {CNT_W{1'b0}})) begin
                        r_key_n <= key_N;
                        r_key_m <= key_M;
                        r_i     <= {KEY_WIDTH{1'b0}};
                        r_j     <= {KEY_WIDTH{1'b0}};
                        busy    <= 1'b1;
                        r_state <= ST_DECRYPT;
                    end
                end
                ST_DECRYPT: begin
                    data_o  <= w_rd_data;
                    valid_o <= 1'b1;
                    if (w_row_last) begin
                        r_i <= {KEY_WIDTH{1'b0}};
                        if (w_col_last) begin
                            r_j     <= {KEY_WIDTH{1'b0}};
                            r_cnt   <= {CNT_W{1'b0}};
                            busy    <= 1'b0;
                            r_state <= ST_COLLECT;
                        end else begin
                            r_j <= r_j + KEY_WIDTH'(1);
                        end
                    end else begin
                        r_i <= r_i + KEY_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_i     <= {KEY_WIDTH{1'b0}};
                    r_j     <= {KEY_WIDTH{1'b0}};
                    data_o  <= {D_WIDTH{1'b0}};
                    valid_o <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scytale_decryption.sv
// Scoreboard bench for scytale_decryption: a queue-based reference model predicts each message's
// plaintext, and a negedge monitor checks every presented output against it.
module tb_scytale_decryption;

    localparam logic [7:0] TOKEN = 8'hFA;
    localparam int MAXC = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic [7:0] key_N = 8'd1;
    logic [7:0] key_M = 8'd1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] coll[$];
    int total = 0;
    int bad = 0;
    int out_seen = 0;

    scytale_decryption dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .key_N(key_N), .key_M(key_M), .data_o(data_o), .valid_o(valid_o), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plaintext character k is ciphertext[(k mod M)*N + k div M].
    task automatic model_token(output bit started);
        int n, m;
        n = int'(key_N);
        m = int'(key_M);
        started = (coll.size() > 0);
        if (started) begin
            for (int k = 0; k < n * m; k++) begin
                exp_q.push_back('{d: coll[(k % m) * n + (k / m)], last: (k == n * m - 1)});
            end
            coll.delete();
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        bit started;
        data_i  = c;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        if (c == TOKEN) begin
            model_token(started);
            check("busy_after_token", {31'd0, busy}, {31'd0, started});
        end else if (coll.size() < MAXC) begin
            coll.push_back(c);
        end
    endtask

    task automatic send_str(input string s);
        for (int k = 0; k < s.len(); k++) send_char(s[k]);
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] c;
        do c = 8'($urandom_range(0, 255)); while (c == TOKEN);
        return c;
    endfunction

    task automatic wait_idle();
        bit done = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (!busy && exp_q.size() == 0) done = 1;
            else begin @(posedge clk); #1; end
        end
        check("idle_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic drive_while_busy();
        for (int c = 0; c < 400 && busy; c++) begin
            data_i  = 8'($urandom_range(0, 255));
            valid_i = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic random_msg(input int len);
        int m, n;
        m = $urandom_range(1, len);
        n = $urandom_range(1, len / m);
        for (int k = 0; k < len; k++) send_char(rand_char());
        key_N = 8'(n);
        key_M = 8'(m);
        send_char(TOKEN);
    endtask

    // Monitor: every valid_o pops one prediction; idle cycles must show zero data.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (valid_o) begin
                out_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {24'd0, data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("data_o", {24'd0, data_o}, {24'd0, e.d});
                    check("busy_during_output", {31'd0, busy}, {31'd0, !e.last});
                end
            end else begin
                check("idle_data_o", {24'd0, data_o}, 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_o", {24'd0, data_o}, 32'd0);
        check("rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Basic 3x2 message.
        key_N = 8'd3; key_M = 8'd2;
        send_str("ABCDEF");
        send_char(TOKEN);
        wait_idle();

        // Token with an empty buffer is ignored, then a normal message follows.
        send_char(TOKEN);
        repeat (4) begin
            @(posedge clk); #1;
            check("empty_token_busy", {31'd0, busy}, 32'd0);
            check("empty_token_valid", {31'd0, valid_o}, 32'd0);
        end
        key_N = 8'd2; key_M = 8'd2;
        send_str("GHIJ");
        send_char(TOKEN);
        wait_idle();

        // Overflow: only the first 50 of 55 characters are kept.
        for (int k = 0; k < 55; k++) send_char(rand_char());
        key_N = 8'd5; key_M = 8'd10;
        send_char(TOKEN);
        wait_idle();

        // Reset during the third output cycle, then recovery.
        key_N = 8'd3; key_M = 8'd2;
        send_str("ABCDEF");
        base = out_seen;
        send_char(TOKEN);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk); #1;
            if (out_seen >= base + 3) ok = 1;
        end
        check("reach_output3", {31'd0, ok}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_data_o", {24'd0, data_o}, 32'd0);
        check("midrst_valid_o", {31'd0, valid_o}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        coll.delete();
        rst_n = 1'b1;
        key_N = 8'd2; key_M = 8'd3;
        send_str("QRSTUV");
        send_char(TOKEN);
        wait_idle();

        // Traffic while busy must be neither output nor stored.
        key_N = 8'd4; key_M = 8'd3;
        send_str("abcdefghijkl");
        send_char(TOKEN);
        drive_while_busy();
        wait_idle();
        key_N = 8'd1; key_M = 8'd3;
        send_str("xyz");
        send_char(TOKEN);
        wait_idle();

        // Back-to-back messages, second one is WXYZ with 2x2.
        random_msg(12);
        for (int c = 0; c < 400 && busy; c++) begin @(posedge clk); #1; end
        key_N = 8'd2; key_M = 8'd2;
        send_str("WXYZ");
        send_char(TOKEN);
        wait_idle();

        // Randomized messages.
        for (int t = 0; t < 20; t++) begin
            random_msg($urandom_range(1, MAXC));
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
